key_trigger_ctrl: RTL and testbench

//  Input-side front end for the LED animation trigger path. Takes a raw, bouncy,

---
 rtl/ui_pkg.sv | 17 +
 rtl/bit_synchronizer.sv | 24 ++
 rtl/key_trigger_ctrl.sv | 150 +++++++++++++++
 tb/tb_key_trigger_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared UI front-end definitions: key debounce FSM states and 50 MHz default timing.
package ui_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;
    localparam int unsigned DEF_HOLD_CYCLES     = 33_554_432;
    localparam bit          DEF_ACTIVE_LOW      = 1'b1;

endpackage

// File: rtl/bit_synchronizer.sv
// N-flop synchronizer for a single asynchronous input; flops reset to RESET_VAL.
module bit_synchronizer #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/key_trigger_ctrl.sv
// Pushbutton front end: synchronize, debounce, emit press/release/long strobes
// and a stretched `active` level for slow-clock consumers.
module key_trigger_ctrl
    import ui_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic active
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    // With a single-cycle debounce the wait states are skipped entirely.
    localparam bit                DB_IMMEDIATE = (DEBOUNCE_CYCLES == 1);

    key_state_t        state;
    key_state_t        state_next;
    logic              key_sync;
    logic              k;
    logic              db_done;
    logic [DB_W-1:0]   db_cnt;
    logic [LONG_W-1:0] long_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic              press_ev;
    logic              release_ev;
    logic              long_ev;

    bit_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_raw),
        .q     (key_sync)
    );

    assign k       = key_sync ^ ACTIVE_LOW;
    assign db_done = (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (k) state_next = DB_IMMEDIATE ? PRESSED : PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!k)          state_next = IDLE;
                else if (db_done) state_next = PRESSED;
            end
            PRESSED: begin
                if (!k) state_next = DB_IMMEDIATE ? IDLE : RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (k)            state_next = PRESSED;
                else if (db_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        press_ev   = 1'b0;
        release_ev = 1'b0;
        long_ev    = 1'b0;
        case (state)
            IDLE:         press_ev = k && DB_IMMEDIATE;
            PRESS_WAIT:   press_ev = k && db_done;
            PRESSED: begin
                long_ev    = (long_cnt == LONG_LAST);
                release_ev = !k && DB_IMMEDIATE;
            end
            RELEASE_WAIT: release_ev = !k && db_done;
            default: ;
        endcase
        // A press reload wins over the decrement so active never dips on retrigger.
        if (press_ev) begin
            hold_next = HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_next = hold_cnt - HOLD_W'(1);
        end else begin
            hold_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt        <= '0;
            long_cnt      <= '0;
            hold_cnt      <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            active        <= 1'b0;
        end else begin
            press_pulse   <= press_ev;
            release_pulse <= release_ev;
            long_pulse    <= long_ev;
            hold_cnt      <= hold_next;
            active        <= (hold_next != '0);

            if (press_ev) begin
                key_level <= 1'b1;
            end else if (release_ev) begin
                key_level <= 1'b0;
            end

            if ((state == IDLE && k) || (state == PRESSED && !k)) begin
                db_cnt <= DB_ONE;
            end else if (((state == PRESS_WAIT && k) || (state == RELEASE_WAIT && !k)) && !db_done) begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            if (press_ev) begin
                long_cnt <= '0;
            end else if (state == PRESSED && long_cnt != LONG_MAX) begin
                long_cnt <= long_cnt + LONG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_trigger_ctrl.sv
// Scoreboard bench: run-length reference model predicts per-cycle outputs of two key_trigger_ctrl configs.
module tb_key_trigger_ctrl;

    localparam int unsigned SYNC0 = 2, DB0 = 4, LONG0 = 16, HOLD0 = 8;
    localparam bit          AL0   = 1'b1;
    localparam int unsigned SYNC1 = 2, DB1 = 1, LONG1 = 6, HOLD1 = 3;
    localparam bit          AL1   = 1'b0;

    typedef struct {
        int cyc;
        bit lvl;
        bit prs;
        bit rel;
        bit lng;
        bit act;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_raw0 = AL0;
    logic key_raw1 = AL1;
    logic lvl0, prs0, rel0, lng0, act0;
    logic lvl1, prs1, rel1, lng1, act1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    bit   m_level[2];
    int   m_run[2];
    int   m_held[2];
    int   m_since[2];
    bit   r1_val = AL1;
    int   r1_left = 0;

    key_trigger_ctrl #(
        .SYNC_STAGES     (SYNC0),
        .DEBOUNCE_CYCLES (DB0),
        .LONG_CYCLES     (LONG0),
        .HOLD_CYCLES     (HOLD0),
        .ACTIVE_LOW      (AL0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_raw       (key_raw0),
        .key_level     (lvl0),
        .press_pulse   (prs0),
        .release_pulse (rel0),
        .long_pulse    (lng0),
        .active        (act0)
    );

    key_trigger_ctrl #(
        .SYNC_STAGES     (SYNC1),
        .DEBOUNCE_CYCLES (DB1),
        .LONG_CYCLES     (LONG1),
        .HOLD_CYCLES     (HOLD1),
        .ACTIVE_LOW      (AL1)
    ) dut1 (
        .clk           (clk),
        .reset         (reset),
        .key_raw       (key_raw1),
        .key_level     (lvl1),
        .press_pulse   (prs1),
        .release_pulse (rel1),
        .long_pulse    (lng1),
        .active        (act1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int i, input int c, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc %0d: got %b expected %b", name, i, c, act, exp);
        end
    endtask

    task automatic check_entry(input int i, input exp_t e, input logic lvl, input logic prs,
                               input logic rel, input logic lng, input logic act);
        cmp("key_level", i, e.cyc, lvl, e.lvl);
        cmp("press_pulse", i, e.cyc, prs, e.prs);
        cmp("release_pulse", i, e.cyc, rel, e.rel);
        cmp("long_pulse", i, e.cyc, lng, e.lng);
        cmp("active", i, e.cyc, act, e.act);
    endtask

    // Monitor: compare whatever the scoreboard predicted for the edge just taken.
    always @(negedge clk) begin
        if (!reset) begin
            if (q0.size() != 0 && q0[0].cyc == cyc) check_entry(0, q0.pop_front(), lvl0, prs0, rel0, lng0, act0);
            if (q1.size() != 0 && q1[0].cyc == cyc) check_entry(1, q1.pop_front(), lvl1, prs1, rel1, lng1, act1);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_level[i] = 1'b0;
            m_run[i]   = 0;
            m_held[i]  = 0;
            m_since[i] = (i == 0) ? HOLD0 : HOLD1;
        end
    endtask

    // Level flips after `db` consecutive disagreeing samples; long time accrues only
    // on edges where the key was pressed with no pending disagreement.
    task automatic model_step(input int i, input bit k, input int tcyc);
        exp_t e;
        int   db, lg, hd;
        db = (i == 0) ? DB0 : DB1;
        lg = (i == 0) ? LONG0 : LONG1;
        hd = (i == 0) ? HOLD0 : HOLD1;
        e.cyc = tcyc; e.prs = 1'b0; e.rel = 1'b0; e.lng = 1'b0;
        if (m_level[i] && m_run[i] == 0 && m_held[i] < lg) begin
            m_held[i]++;
            if (m_held[i] == lg) e.lng = 1'b1;
        end
        if (k != m_level[i]) m_run[i]++;
        else                 m_run[i] = 0;
        if (m_run[i] == db) begin
            m_level[i] = k;
            m_run[i]   = 0;
            if (k) begin
                e.prs      = 1'b1;
                m_held[i]  = 0;
                m_since[i] = 0;
            end else begin
                e.rel = 1'b1;
            end
        end
        if (!e.prs && m_since[i] < hd) m_since[i]++;
        e.lvl = m_level[i];
        e.act = (m_since[i] < hd);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input bit r0);
        @(negedge clk);
        #1;
        if (r1_left == 0) begin
            r1_val  = ~r1_val;
            r1_left = $urandom_range(1, 12);
        end
        r1_left--;
        key_raw0 = r0;
        key_raw1 = r1_val;
        model_step(0, r0 ^ AL0, cyc + 1 + SYNC0);
        model_step(1, r1_val ^ AL1, cyc + 1 + SYNC1);
    endtask

    task automatic seg(input bit r0, input int len);
        for (int n = 0; n < len; n++) drive(r0);
    endtask

    task automatic check_zero(input int c);
        cmp("rst_key_level", 0, c, lvl0, 1'b0);
        cmp("rst_press", 0, c, prs0, 1'b0);
        cmp("rst_release", 0, c, rel0, 1'b0);
        cmp("rst_long", 0, c, lng0, 1'b0);
        cmp("rst_active", 0, c, act0, 1'b0);
        cmp("rst_key_level", 1, c, lvl1, 1'b0);
        cmp("rst_active", 1, c, act1, 1'b0);
    endtask

    // Synchronizer flops hold the released level for SYNC edges after reset.
    task automatic release_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        for (int s = 1; s <= SYNC0; s++) model_step(0, 1'b0, cyc + s);
        for (int s = 1; s <= SYNC1; s++) model_step(1, 1'b0, cyc + s);
        model_step(0, key_raw0 ^ AL0, cyc + 1 + SYNC0);
        model_step(1, key_raw1 ^ AL1, cyc + 1 + SYNC1);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_zero(cyc);
        q0.delete();
        q1.delete();
        model_reset();
        repeat (3) @(negedge clk);
        release_reset();
    endtask

    initial begin
        int len;
        bit lv;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero(cyc);
        release_reset();

        seg(1, 10); seg(0, 30); seg(1, 20);                     // clean press with long
        seg(0, 3); seg(1, 2); seg(0, 3); seg(1, 15);            // press bounce
        seg(0, 10); seg(1, 2); seg(0, 20); seg(1, 15);          // release bounce
        seg(0, 4); seg(1, 4); seg(0, 10); seg(1, 15);           // tightest retrigger
        seg(1, 5); seg(0, 8);                                   // held and active
        reset_mid();
        seg(0, 15); seg(1, 15);

        lv = 1'b1;
        for (int s = 0; s < 120; s++) begin
            lv = ~lv;
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 3);
                1:       len = $urandom_range(4, 6);
                2:       len = $urandom_range(7, 20);
                default: len = $urandom_range(20, 40);
            endcase
            seg(lv, len);
            if (s == 60) reset_mid();
        end
        seg(1, 12);

        for (int w = 0; w < 10 && (q0.size() + q1.size()) != 0; w++) @(negedge clk);
        n_cmp++;
        if ((q0.size() + q1.size()) != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", q0.size() + q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
